pulse_width_decoder: RTL and testbench

- Receive end of the pulse-stretch path: samples an asynchronous, level-stretched `pulse_in` and measures each high pulse in `clk` cycles.
- Rejects glitches shorter than `MIN_WIDTH` and flags pulses stuck high longer than `MAX_WIDTH`.
- Delivers each accepted width as one entry on a valid/ready output.
- Sits between an incoming stretched-event line and event-consuming control logic.

---
 rtl/pulse_width_decoder.sv | 137 +++++++++++++
 tb/tb_pulse_width_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_decoder.sv
// Measures the width of each high pulse on an asynchronous stretched line,
// rejects glitches and stuck-high pulses, and buffers one result on a valid/ready port.
module pulse_width_decoder #(
    parameter int CNT_W       = 8,
    parameter int MIN_WIDTH   = 2,
    parameter int MAX_WIDTH   = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             width_valid,
    input  logic             width_ready,
    output logic [CNT_W-1:0] width_data,
    output logic             overflow,
    output logic             stuck_err,
    input  logic             clear_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_STUCK
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_result;
    logic                   w_stuck_set;
    logic                   r_valid;
    logic [CNT_W-1:0]       r_data;
    logic                   r_ovf;
    logic                   r_stuck;

    // Input synchroniser; only its last stage feeds the measurement logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_result    = 1'b0;
        w_stuck_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_MEASURE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (w_s) begin
                    // Counter saturates at MAX_WIDTH, so it can never wrap
                    if (r_cnt == MAX_C) begin
                        w_state_nxt = ST_STUCK;
                        w_stuck_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_result    = (r_cnt >= MIN_C);
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STUCK: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One-entry output buffer: a result arriving while the held value is
    // being accepted replaces it; otherwise a full buffer drops it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_result) begin
            if (!r_valid || width_ready) begin
                r_valid <= 1'b1;
                r_data  <= r_cnt;
            end
        end else if (r_valid && width_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            if (w_result && r_valid && !width_ready) begin
                r_ovf <= 1'b1;
            end else if (clear_err) begin
                r_ovf <= 1'b0;
            end
            if (w_stuck_set) begin
                r_stuck <= 1'b1;
            end else if (clear_err) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign width_valid = r_valid;
    assign width_data  = r_data;
    assign overflow    = r_ovf;
    assign stuck_err   = r_stuck;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder: expected widths are queued as
// pulses are driven and compared on every output transfer.
module tb_pulse_width_decoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             pulse_in;
    logic             width_valid;
    logic             width_ready;
    logic [CNT_W-1:0] width_data;
    logic             overflow;
    logic             stuck_err;
    logic             clear_err;

    int n_checks;
    int n_pass;
    int exp_q[$];

    pulse_width_decoder #(
        .CNT_W(CNT_W),
        .MIN_WIDTH(2),
        .MAX_WIDTH(200),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulse_in),
        .width_valid(width_valid),
        .width_ready(width_ready),
        .width_data(width_data),
        .overflow(overflow),
        .stuck_err(stuck_err),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 2ns after the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int n);
        pulse_in = 1'b1;
        repeat (n) tick();
        pulse_in = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !width_valid) break;
            tick();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Transfers happen at the next posedge when valid && ready hold at the negedge
    always @(negedge clk) begin
        if (!rst && width_valid && width_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", width_data, 0);
            end else begin
                chk("width", width_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        pulse_in    = 1'b0;
        width_ready = 1'b1;
        clear_err   = 1'b0;
        #1;
        chk("rst_valid", width_valid, 0);
        chk("rst_data", width_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_stuck", stuck_err, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Width 5 with latency: valid rises after edge 3 of the low samples, one cycle only
        exp_q.push_back(5);
        send(5);
        tick();
        tick();
        chk("lat_e2_valid", width_valid, 0);
        tick();
        chk("lat_e3_valid", width_valid, 1);
        chk("lat_e3_data", width_data, 5);
        tick();
        chk("lat_e4_valid", width_valid, 0);
        wait_drain();

        // Glitch of one cycle, then minimum width
        send(1);
        repeat (6) tick();
        chk("glitch_valid", width_valid, 0);
        exp_q.push_back(2);
        send(2);
        repeat (3) tick();
        wait_drain();

        // Maximum width accepted; one more cycle is stuck
        exp_q.push_back(200);
        send(200);
        repeat (4) tick();
        wait_drain();
        chk("max_stuck", stuck_err, 0);
        pulse_in = 1'b1;
        repeat (202) tick();
        chk("stuck_before", stuck_err, 0);
        tick();
        chk("stuck_after", stuck_err, 1);
        repeat (47) tick();
        pulse_in = 1'b0;
        repeat (8) tick();
        chk("stuck_noresult", width_valid, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("stuck_clear", stuck_err, 0);

        // Overflow: 4 held, 7 dropped
        width_ready = 1'b0;
        exp_q.push_back(4);
        send(4);
        repeat (4) tick();
        send(7);
        repeat (5) tick();
        chk("ovf_valid", width_valid, 1);
        chk("ovf_data", width_data, 4);
        chk("ovf_flag", overflow, 1);
        width_ready = 1'b1;
        tick();
        tick();
        chk("ovf_drained", width_valid, 0);
        chk("ovf_q", exp_q.size(), 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Accept and replace in the same cycle
        width_ready = 1'b0;
        exp_q.push_back(4);
        send(4);
        repeat (5) tick();
        chk("sc_hold_data", width_data, 4);
        exp_q.push_back(9);
        send(9);
        tick();
        tick();
        width_ready = 1'b1;
        tick();
        width_ready = 1'b0;
        chk("sc_valid", width_valid, 1);
        chk("sc_data", width_data, 9);
        chk("sc_ovf", overflow, 0);
        width_ready = 1'b1;
        wait_drain();

        // Reset in the 3rd high cycle of a pulse, released while still high
        pulse_in = 1'b1;
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", width_valid, 0);
        chk("mid_rst_data", width_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_stuck", stuck_err, 0);
        tick();
        rst = 1'b0;
        exp_q.push_back(4);
        repeat (4) tick();
        pulse_in = 1'b0;
        repeat (3) tick();
        wait_drain();
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
